// File: rtl/sram_axi_bridge.sv
// Bridges an instruction and a data SRAM-like port onto a single AXI master.
// One transaction is in flight at a time. Data requests win ties against instruction requests.
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction SRAM-like port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data SRAM-like port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RD_ADDR      = 3'd1,
    RD_DATA      = 3'd2,
    WR_ADDR_DATA = 3'd3,
    WR_RESP      = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic        src_data_q, src_data_d;
  logic        wr_q, wr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        inst_data_ok_q, inst_data_ok_d;
  logic        data_data_ok_q, data_data_ok_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic        idle_open_s;
  logic        data_accept_s;
  logic        inst_accept_s;
  logic        aw_done_s;
  logic        w_done_s;
  logic        unused_s;

  function automatic logic [3:0] wstrb_f(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << off;
      2'd1:    strb = off[1] ? 4'b1100 : 4'b0011;
      2'd2:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Acceptance is held off during reset and in the data_ok cycle so a new request lands one cycle later.
  assign idle_open_s   = (state_q == IDLE) && rst && !inst_data_ok_q && !data_data_ok_q;
  assign data_accept_s = idle_open_s && data_req;
  assign inst_accept_s = idle_open_s && inst_req && !data_req;
  assign data_addr_ok  = data_accept_s;
  assign inst_addr_ok  = inst_accept_s;

  assign aw_done_s = aw_done_q | (awvalid_q & awready);
  assign w_done_s  = w_done_q | (wvalid_q & wready);

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    size_d         = size_q;
    wdata_d        = wdata_q;
    src_data_d     = src_data_q;
    wr_d           = wr_q;
    arvalid_d      = arvalid_q;
    rready_d       = rready_q;
    awvalid_d      = awvalid_q;
    wvalid_d       = wvalid_q;
    bready_d       = bready_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    inst_data_ok_d = 1'b0;
    data_data_ok_d = 1'b0;
    inst_rdata_d   = inst_rdata_q;
    data_rdata_d   = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (data_accept_s || inst_accept_s) begin
          addr_d     = data_accept_s ? data_addr  : inst_addr;
          size_d     = data_accept_s ? data_size  : inst_size;
          wdata_d    = data_accept_s ? data_wdata : inst_wdata;
          src_data_d = data_accept_s;
          wr_d       = data_accept_s && data_wr;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          if (data_accept_s && data_wr) begin
            state_d   = WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rready_d = 1'b0;
          state_d  = IDLE;
          if (src_data_q) begin
            data_data_ok_d = 1'b1;
            data_rdata_d   = rdata;
          end else begin
            inst_data_ok_d = 1'b1;
            inst_rdata_d   = rdata;
          end
        end else begin
          state_d = RD_DATA;
        end
      end
      WR_ADDR_DATA: begin
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        aw_done_d = aw_done_s;
        w_done_d  = w_done_s;
        if (aw_done_s && w_done_s) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end else begin
          state_d = WR_ADDR_DATA;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bready_d       = 1'b0;
          data_data_ok_d = 1'b1;
          state_d        = IDLE;
        end else begin
          state_d = WR_RESP;
        end
      end
      default: begin
        state_d   = IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      addr_q         <= 32'd0;
      size_q         <= 2'd0;
      wdata_q        <= 32'd0;
      src_data_q     <= 1'b0;
      wr_q           <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      inst_rdata_q   <= 32'd0;
      data_rdata_q   <= 32'd0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      size_q         <= size_d;
      wdata_q        <= wdata_d;
      src_data_q     <= src_data_d;
      wr_q           <= wr_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      bready_q       <= bready_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      inst_data_ok_q <= inst_data_ok_d;
      data_data_ok_q <= data_data_ok_d;
      inst_rdata_q   <= inst_rdata_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  assign inst_rdata   = inst_rdata_q;
  assign inst_data_ok = inst_data_ok_q;
  assign data_rdata   = data_rdata_q;
  assign data_data_ok = data_data_ok_q;

  assign arid    = src_data_q ? DATA_ID : INST_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = DATA_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = awvalid_q;
  assign wid     = DATA_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_f(size_q, addr_q[1:0]);
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  // Response IDs, response codes and rlast carry no information for single-beat, in-order traffic.
  assign unused_s = ^{inst_wr, wr_q, rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench for sram_axi_bridge: a reactive AXI slave with programmable stalls,
// an SRAM-side driver, and a monitor that pops expected responses on every data_ok.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = 2'd0;
  logic [31:0] inst_addr = 32'd0, inst_wdata = 32'd0;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
  logic [31:0] data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, wid, arcache, awcache;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, awvalid, wvalid, rready, bready, wlast;
  logic [3:0]  wstrb;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b1, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  rid = 4'd0, bid = 4'd1;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00, bresp = 2'b00;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_data;
    bit          is_wr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rdq[$];
  int          ok_count    = 0;
  int          last_ok_cyc = 0;
  int          acc_cyc     = 0;

  // slave knobs and captured handshake values
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb, cap_awid, cap_wid;
  logic [2:0]  cap_awsize;
  logic        cap_wlast;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0;

  // Reactive AXI slave: drives readies/valids at negedge, checks stability during stalls.
  initial begin
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit ar_stall = 0, aw_stall = 0, w_stall = 0, aw_fired = 0, w_fired = 0;
    logic [31:0] ar_addr_p = 32'd0, aw_addr_p = 32'd0, w_data_p = 32'd0;
    logic [3:0]  ar_id_p = 4'd0, w_strb_p = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        ar_stall = 0; aw_stall = 0; w_stall = 0; aw_fired = 0; w_fired = 0;
      end else begin
        if (arvalid) begin
          if (ar_stall) begin
            chk("ar_hold_addr", araddr, ar_addr_p);
            chk("ar_hold_id", 32'(arid), 32'(ar_id_p));
          end
          if (ar_cnt >= ar_wait) begin
            arready = 1'b1; ar_cnt = 0; ar_stall = 0; cap_araddr = araddr;
          end else begin
            arready = 1'b0; ar_cnt++; ar_stall = 1; ar_addr_p = araddr; ar_id_p = arid;
          end
        end else begin
          if (ar_stall) chk("ar_hold_valid", 32'(arvalid), 32'd1);
          arready = 1'b0; ar_cnt = 0; ar_stall = 0;
        end
        if (rready) begin
          if (r_cnt >= r_wait) begin
            rvalid = 1'b1;
            rdata  = (rdq.size() != 0) ? rdq.pop_front() : 32'hDEAD_BEEF;
          end else begin
            rvalid = 1'b0; r_cnt++;
          end
        end else begin
          rvalid = 1'b0; r_cnt = 0;
        end
        if (aw_fired) chk("aw_drop", 32'(awvalid), 32'd0);
        aw_fired = 0;
        if (awvalid) begin
          if (aw_stall) chk("aw_hold_addr", awaddr, aw_addr_p);
          if (aw_cnt >= aw_wait) begin
            awready = 1'b1; aw_cnt = 0; aw_stall = 0; aw_fired = 1; aw_hs_cyc = cyc;
            cap_awaddr = awaddr; cap_awid = awid; cap_awsize = awsize;
          end else begin
            awready = 1'b0; aw_cnt++; aw_stall = 1; aw_addr_p = awaddr;
          end
        end else begin
          if (aw_stall) chk("aw_hold_valid", 32'(awvalid), 32'd1);
          awready = 1'b0; aw_cnt = 0; aw_stall = 0;
        end
        if (w_fired) chk("w_drop", 32'(wvalid), 32'd0);
        w_fired = 0;
        if (wvalid) begin
          if (w_stall) begin
            chk("w_hold_data", wdata, w_data_p);
            chk("w_hold_strb", 32'(wstrb), 32'(w_strb_p));
          end
          if (w_cnt >= w_wait) begin
            wready = 1'b1; w_cnt = 0; w_stall = 0; w_fired = 1; w_hs_cyc = cyc;
            cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast; cap_wid = wid;
          end else begin
            wready = 1'b0; w_cnt++; w_stall = 1; w_data_p = wdata; w_strb_p = wstrb;
          end
        end else begin
          if (w_stall) chk("w_hold_valid", 32'(wvalid), 32'd1);
          wready = 1'b0; w_cnt = 0; w_stall = 0;
        end
        if (bready) begin
          if (b_cnt >= b_wait) begin
            bvalid = 1'b1; b_hs_cyc = cyc;
          end else begin
            bvalid = 1'b0; b_cnt++;
          end
        end else begin
          bvalid = 1'b0; b_cnt = 0;
        end
      end
    end
  end

  // Response monitor: every data_ok pops one scoreboard entry.
  initial begin
    bit prev_ok = 0;
    forever begin
      @(negedge clk);
      if (rst && (inst_data_ok || data_data_ok)) begin
        exp_t e;
        chk("ok_onehot", 32'(inst_data_ok & data_data_ok), 32'd0);
        chk("ok_width", 32'(prev_ok), 32'd0);
        ok_count++;
        last_ok_cyc = cyc;
        if (sb.size() == 0) begin
          chk("sb_unexpected_ok", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ok_src", 32'(data_data_ok), 32'(e.is_data));
          if (!e.is_wr) chk("rdata", data_data_ok ? data_rdata : inst_rdata, e.rdata);
        end
      end
      prev_ok = rst && (inst_data_ok || data_data_ok);
    end
  end

  task automatic issue(input bit is_data, input bit wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd);
    exp_t e;
    bit got = 0;
    @(negedge clk);
    if (is_data) begin
      data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    end else begin
      inst_req = 1'b1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd;
    end
    e.is_data = is_data; e.is_wr = wr; e.rdata = exp_rd;
    sb.push_back(e);
    if (!wr) rdq.push_back(exp_rd);
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (is_data ? data_addr_ok : inst_addr_ok) begin
        got = 1;
        acc_cyc = cyc;
        chk("other_addr_ok", 32'(is_data ? inst_addr_ok : data_addr_ok), 32'd0);
      end
      @(negedge clk);
    end
    chk("accept", 32'(got), 32'd1);
    inst_req = 1'b0;
    data_req = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                          input logic [3:0] exp_strb, input int aw_w, input int w_w, input int b_w);
    int ok_before;
    aw_wait = aw_w; w_wait = w_w; b_wait = b_w;
    ok_before = ok_count;
    issue(1'b1, 1'b1, size, addr, wd, 32'd0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("wr_awaddr", cap_awaddr, addr);
    chk("wr_wstrb", 32'(cap_wstrb), 32'(exp_strb));
    chk("wr_wdata", cap_wdata, wd);
    chk("wr_wlast", 32'(cap_wlast), 32'd1);
    chk("wr_ids", 32'({cap_awid, cap_wid}), 32'h11);
    chk("wr_awsize", 32'(cap_awsize), 32'(size));
    chk("wr_hs_gap", 32'(w_hs_cyc - aw_hs_cyc), 32'(w_w - aw_w));
    chk("wr_ok_after_b", 32'(last_ok_cyc - b_hs_cyc), 32'd1);
    chk("wr_single_ok", 32'(ok_count - ok_before), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    int inst_acc;
    int ok_before;
    // reset state, with requests pending to prove nothing is accepted
    inst_req = 1'b1; data_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    chk("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
    chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    chk("rst_rdata", inst_rdata | data_rdata, 32'd0);
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // boot-vector instruction read, minimum latency
    issue(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'd0, 32'h3C1D_0001);
    chk("rd_arvalid", 32'(arvalid), 32'd1);
    chk("rd_araddr", araddr, 32'hBFC0_0000);
    chk("rd_arid", 32'(arid), 32'd0);
    chk("rd_arfields", {arlen, 5'd0, arsize, 6'd0, arburst, arlock, 4'd0, arcache, 1'b0, arprot},
        {8'd0, 5'd0, 3'd2, 6'd0, 2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 3'd0});
    wait_done();
    chk("rd_latency", 32'(last_ok_cyc - acc_cyc), 32'd3);
    repeat (2) @(negedge clk);
    chk("rd_rdata_hold", inst_rdata, 32'h3C1D_0001);

    // simultaneous requests: data wins, inst follows the cycle after data_ok
    @(negedge clk);
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0000_1000;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_2000;
    begin
      exp_t e;
      e.is_data = 1'b1; e.is_wr = 1'b0; e.rdata = 32'h1111_1111; sb.push_back(e);
      e.is_data = 1'b0; e.is_wr = 1'b0; e.rdata = 32'h2222_2222; sb.push_back(e);
    end
    rdq.push_back(32'h1111_1111);
    rdq.push_back(32'h2222_2222);
    #1;
    chk("sim_data_first", 32'({data_addr_ok, inst_addr_ok}), 32'b10);
    @(negedge clk);
    data_req = 1'b0;
    chk("sim_arid_data", 32'(arid), 32'd1);
    got = 0;
    inst_acc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (inst_addr_ok) begin
        got = 1;
        inst_acc = cyc;
      end
      @(negedge clk);
    end
    inst_req = 1'b0;
    chk("sim_inst_accept", 32'(got), 32'd1);
    chk("sim_inst_after_ok", 32'(inst_acc - last_ok_cyc), 32'd1);
    chk("sim_arid_inst", 32'(arid), 32'd0);
    wait_done();

    // writes: byte with aw before w, halfword, word with aw/w together
    do_write(32'h8000_0003, 2'd0, 32'hAB00_0000, 4'b1000, 0, 2, 1);
    do_write(32'h8000_0002, 2'd1, 32'h1234_0000, 4'b1100, 1, 0, 0);
    do_write(32'h8000_0001, 2'd0, 32'h0000_5600, 4'b0010, 0, 0, 0);
    do_write(32'h8000_0004, 2'd2, 32'hCAFE_F00D, 4'b1111, 0, 0, 2);

    // address stall with error response
    ar_wait = 5;
    rresp = 2'b10;
    issue(1'b1, 1'b0, 2'd2, 32'h9000_0004, 32'd0, 32'h0BAD_F00D);
    wait_done();
    chk("stall_araddr", cap_araddr, 32'h9000_0004);
    ar_wait = 0;
    rresp = 2'b00;

    // reset while stalled in read data
    r_wait = 1000;
    issue(1'b0, 1'b0, 2'd2, 32'h0000_0400, 32'd0, 32'h5555_5555);
    for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
    chk("rst_mid_rready", 32'(rready), 32'd1);
    ok_before = ok_count;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    rdq.delete();
    #1;
    chk("rst_mid_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
    chk("rst_mid_rdata", inst_rdata | data_rdata, 32'd0);
    r_wait = 0;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_ok", 32'(ok_count - ok_before), 32'd0);
    issue(1'b0, 1'b0, 2'd2, 32'h0000_0800, 32'd0, 32'h7777_0001);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
